// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - iterative binary-to-BCD converter with seven-segment score display
// One add-3/shift step per clock; results, hex patterns and overflow are registered together with done.
module count_bcd_display #(
  parameter int WIDTH    = 20,
  parameter int DIGITS   = 6,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      val,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [6:0]            hex4,
  output logic [6:0]            hex5
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NH = (DIGITS > 6) ? DIGITS : 6;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]      MAXV64 = pow10(DIGITS) - 64'd1;
  localparam bit               SAT_EN = (WIDTH >= 64) ? 1'b1 : (MAXV64 < (64'd1 << WIDTH));
  localparam logic [WIDTH-1:0] MAXV_W = WIDTH'(MAXV64);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Scan from the most significant digit so a zero stays blank only until a non-zero digit is seen.
  function automatic logic [7*NH-1:0] encode_hex(input logic [4*NH-1:0] b);
    logic [7*NH-1:0] h;
    logic            seen;
    h    = '0;
    seen = 1'b0;
    for (int k = NH - 1; k >= 0; k--) begin
      if (b[4*k +: 4] != 4'd0) seen = 1'b1;
      if (BLANK_LZ && (k != 0) && !seen) h[7*k +: 7] = 7'h7F;
      else                               h[7*k +: 7] = seg7(b[4*k +: 4]);
    end
    return h;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_scr;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_pend;
  logic [BW-1:0]    r_bcd;
  logic             r_ovf;
  logic [7*NH-1:0]  r_hex;

  logic             w_accept;
  logic             w_last;
  logic             w_over;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_scr_nxt;
  logic [4*NH-1:0]  w_bcd_ext;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(1));
  assign w_over   = SAT_EN && (val > MAXV_W);

  always_comb begin
    w_adj = r_scr;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scr[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_scr[4*k +: 4] + 4'd3;
    end
  end

  // The adjusted scratch never carries out of the top digit because the captured value is <= MAXV.
  assign w_scr_nxt = BW'({w_adj, r_bin[WIDTH-1]});

  always_comb begin
    w_bcd_ext         = '0;
    w_bcd_ext[BW-1:0] = w_scr_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_hex      <= encode_hex('0);
    end else if (w_accept) begin
      r_bin      <= w_over ? MAXV_W : val;
      r_ovf_pend <= w_over;
      r_scr      <= '0;
      r_cnt      <= CW'(WIDTH);
    end else if (r_state == S_SHIFT) begin
      r_scr <= w_scr_nxt;
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_bcd <= w_scr_nxt;
        r_hex <= encode_hex(w_bcd_ext);
        r_ovf <= r_ovf_pend;
      end
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign ovf  = r_ovf;
  assign bcd  = r_bcd;
  assign hex0 = r_hex[6:0];
  assign hex1 = r_hex[13:7];
  assign hex2 = r_hex[20:14];
  assign hex3 = r_hex[27:21];
  assign hex4 = r_hex[34:28];
  assign hex5 = r_hex[41:35];

endmodule
